// File: rtl/conv_pkg.sv
// Shared defaults, FSM encoding and tap indexing for the 3x3 window generator.
package conv_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_IMG_W  = 640;
  localparam int unsigned DEF_IMG_H  = 640;
  localparam int unsigned DEF_CNT_W  = 15;

  typedef enum logic [1:0] {
    StRun,
    StPad,
    StDrain
  } state_e;

  // Flat slot of tap (r,c) inside the packed window bus.
  function automatic int unsigned tap(input int unsigned r, input int unsigned c);
    return 3 * r + c;
  endfunction

endpackage

// File: rtl/line_buffer_ram.sv
// Single-port line store, combinational read of the old word, write at the same address.
module line_buffer_ram #(
  parameter int unsigned DEPTH  = 640,
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/conv3x3_window_gen.sv
// Zero-padded 3x3 window generator: two line buffers plus a 3-column shift window,
// with internal right-pad and bottom-drain steps so every output pixel gets one window.
module conv3x3_window_gen
  import conv_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned IMG_W  = DEF_IMG_W,
  parameter int unsigned IMG_H  = DEF_IMG_H,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_pixel,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [9*DATA_W-1:0] out_win,
  output logic [CNT_W-1:0]    out_row,
  output logic [CNT_W-1:0]    out_col,
  output logic                out_last
);

  localparam int unsigned      LB_AW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(IMG_H - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  state_e            state_q;
  logic              drain_q;
  logic [CNT_W-1:0]  in_row_q, in_col_q;
  logic [DATA_W-1:0] win_q [3][3];  // [column][row]
  logic [DATA_W-1:0] win_d [3][3];
  logic [DATA_W-1:0] col_vec [3];   // top, mid, bot

  logic                advance, step, lb_we, left_pad;
  logic                emit, emit_last;
  logic [CNT_W-1:0]    emit_row, emit_col;
  logic [2*DATA_W-1:0] lb_rd;
  logic [DATA_W-1:0]   lb1_rd, lb0_rd;
  logic [9*DATA_W-1:0] win_flat;

  assign lb1_rd = lb_rd[2*DATA_W-1:DATA_W];
  assign lb0_rd = lb_rd[DATA_W-1:0];

  line_buffer_ram #(
    .DEPTH  (IMG_W),
    .WIDTH  (2 * DATA_W),
    .ADDR_W (LB_AW)
  ) u_line_buffer (
    .clk   (clk),
    .we    (lb_we),
    .addr  (in_col_q[LB_AW-1:0]),
    .wdata ({lb0_rd, col_vec[2]}),
    .rdata (lb_rd)
  );

  always_comb begin
    advance  = !out_valid || out_ready;
    in_ready = (state_q == StRun) && advance && !reset;
    step     = advance && ((state_q == StRun) ? in_valid : 1'b1);
    lb_we    = step && (state_q != StPad) && !reset;
    left_pad = (state_q != StPad) && (in_col_q == '0);

    col_vec[0] = '0;
    col_vec[1] = '0;
    col_vec[2] = '0;
    emit       = 1'b0;
    emit_last  = 1'b0;
    emit_row   = in_row_q;
    emit_col   = in_col_q - ONE;
    unique case (state_q)
      StRun: begin
        // Row 1 has no row above; LB1 still holds the previous frame there.
        col_vec[0] = (in_row_q == ONE) ? '0 : lb1_rd;
        col_vec[1] = lb0_rd;
        col_vec[2] = in_pixel;
        emit       = (in_row_q != '0) && (in_col_q != '0);
        emit_row   = in_row_q - ONE;
      end
      StDrain: begin
        col_vec[0] = lb1_rd;
        col_vec[1] = lb0_rd;
        emit       = (in_col_q != '0);
      end
      StPad: begin
        // Row 0 also takes a pad step to keep a uniform IMG_W+1 row period.
        emit      = drain_q || (in_row_q != '0);
        emit_row  = drain_q ? in_row_q : in_row_q - ONE;
        emit_col  = LAST_COL;
        emit_last = drain_q;
      end
      default: ;
    endcase

    for (int r = 0; r < 3; r++) begin
      win_d[0][r] = left_pad ? '0 : win_q[1][r];
      win_d[1][r] = left_pad ? '0 : win_q[2][r];
      win_d[2][r] = col_vec[r];
    end

    win_flat = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        win_flat[DATA_W*tap(r, c) +: DATA_W] = win_d[c][r];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StRun;
      drain_q   <= 1'b0;
      in_row_q  <= '0;
      in_col_q  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_row   <= '0;
      out_col   <= '0;
      out_win   <= '0;
      for (int c = 0; c < 3; c++) begin
        for (int r = 0; r < 3; r++) begin
          win_q[c][r] <= '0;
        end
      end
    end else if (step) begin
      win_q     <= win_d;
      out_valid <= emit;
      if (emit) begin
        out_win  <= win_flat;
        out_row  <= emit_row;
        out_col  <= emit_col;
        out_last <= emit_last;
      end
      unique case (state_q)
        StRun: begin
          if (in_col_q == LAST_COL) begin
            in_col_q <= '0;
            state_q  <= StPad;
          end else begin
            in_col_q <= in_col_q + ONE;
          end
        end
        StPad: begin
          if (drain_q) begin
            drain_q  <= 1'b0;
            in_row_q <= '0;
            in_col_q <= '0;
            state_q  <= StRun;
          end else if (in_row_q == LAST_ROW) begin
            drain_q <= 1'b1;
            state_q <= StDrain;
          end else begin
            in_row_q <= in_row_q + ONE;
            state_q  <= StRun;
          end
        end
        StDrain: begin
          if (in_col_q == LAST_COL) begin
            in_col_q <= '0;
            state_q  <= StPad;
          end else begin
            in_col_q <= in_col_q + ONE;
          end
        end
        default: state_q <= StRun;
      endcase
    end else if (advance) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv3x3_window_gen.sv
// Directed bench for conv3x3_window_gen on a 4x3 ramp image, pixel(r,c) = 10*r+c+1.
module tb_conv3x3_window_gen;

  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int CW = 15;
  localparam int WW = 9 * DW;

  logic          clk = 1'b0;
  logic          reset, in_valid, in_ready, out_valid, out_ready, out_last;
  logic [DW-1:0] in_pixel;
  logic [WW-1:0] out_win;
  logic [CW-1:0] out_row, out_col;

  always #5 clk = ~clk;

  conv3x3_window_gen #(
    .DATA_W (DW),
    .IMG_W  (W),
    .IMG_H  (H),
    .CNT_W  (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pixel  (in_pixel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_win   (out_win),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_last  (out_last)
  );

  typedef struct {
    int            row;
    int            col;
    logic [WW-1:0] win;
    logic          last;
  } vec_t;

  vec_t          exp_tab [W*H];
  int            got_row [$];
  int            got_col [$];
  logic [WW-1:0] got_win [$];
  logic          got_last [$];

  int n_checks = 0;
  int n_fails  = 0;
  int rdy_mode = 0;
  bit meas     = 1'b1;
  int acc_cnt  = 0;
  int low_cnt  = 0;
  int cyc_cnt  = 0;

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic logic [DW-1:0] pix(input int r, input int c);
    return DW'(10 * r + c + 1);
  endfunction

  function automatic logic [WW-1:0] win_model(input int rc, input int cc);
    logic [WW-1:0] w = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        int pr = rc + r - 1;
        int pc = cc + c - 1;
        if (pr >= 0 && pr < H && pc >= 0 && pc < W) w[DW*(3*r+c) +: DW] = pix(pr, pc);
      end
    end
    return w;
  endfunction

  function automatic logic [WW-1:0] win9(input int t0, input int t1, input int t2,
                                         input int t3, input int t4, input int t5,
                                         input int t6, input int t7, input int t8);
    logic [WW-1:0] w;
    w = {DW'(t8), DW'(t7), DW'(t6), DW'(t5), DW'(t4), DW'(t3), DW'(t2), DW'(t1), DW'(t0)};
    return w;
  endfunction

  always @(negedge clk) begin
    if (meas && acc_cnt >= 1 && acc_cnt <= W * H) begin
      cyc_cnt++;
      if (!in_ready) low_cnt++;
    end
    if (!reset && in_valid && in_ready) acc_cnt++;
    if (!reset && out_valid && out_ready) begin
      got_row.push_back(int'(out_row));
      got_col.push_back(int'(out_col));
      got_win.push_back(out_win);
      got_last.push_back(out_last);
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 1) out_ready = ~out_ready;
      else out_ready = 1'b1;
    end
  end

  task automatic clear_q();
    got_row.delete();
    got_col.delete();
    got_win.delete();
    got_last.delete();
  endtask

  task automatic send_pixel(input logic [DW-1:0] p, input bit gaps);
    int  n;
    bit  acc;
    if (gaps) begin
      n = $urandom_range(0, 2);
      in_valid = 1'b0;
      repeat (n) begin
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b1;
    in_pixel = p;
    n = 0;
    forever begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      n++;
      if (n > 200) begin
        n_checks++;
        n_fails++;
        $display("FAIL accept_timeout: pixel %0d not accepted, required within 200 cycles", p);
        break;
      end
    end
  endtask

  task automatic send_frame(input bit gaps);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) send_pixel(pix(r, c), gaps);
    end
  endtask

  task automatic wait_windows(input string tag, input int n);
    int k = 0;
    while (got_win.size() < n && k < 500) begin
      @(posedge clk);
      k++;
    end
    repeat (20) @(posedge clk);
    #1;
    chk($sformatf("%s_win_count", tag), WW'(got_win.size()), WW'(n));
  endtask

  task automatic compare_frame(input string tag, input int base);
    for (int i = 0; i < W * H; i++) begin
      chk($sformatf("%s_row[%0d]", tag, i), WW'(got_row[base+i]), WW'(exp_tab[i].row));
      chk($sformatf("%s_col[%0d]", tag, i), WW'(got_col[base+i]), WW'(exp_tab[i].col));
      chk($sformatf("%s_win[%0d]", tag, i), got_win[base+i], exp_tab[i].win);
      chk($sformatf("%s_last[%0d]", tag, i), WW'(got_last[base+i]), WW'(exp_tab[i].last));
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_pixel = '0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        exp_tab[r*W+c] = '{r, c, win_model(r, c), (r == H - 1 && c == W - 1)};
      end
    end

    // Reset state
    @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", WW'(out_valid), WW'(0));
    chk("rst_out_last", WW'(out_last), WW'(0));
    chk("rst_out_row", WW'(out_row), WW'(0));
    chk("rst_out_col", WW'(out_col), WW'(0));
    chk("rst_out_win", out_win, '0);
    chk("rst_in_ready", WW'(in_ready), WW'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Two back-to-back frames at full rate
    send_frame(1'b0);
    send_frame(1'b0);
    in_valid = 1'b0;
    wait_windows("b2b", 2 * W * H);
    meas = 1'b0;
    compare_frame("f1", 0);
    compare_frame("f2", W * H);
    chk("hand_c00", got_win[0], win9(0, 0, 0, 0, 1, 2, 0, 11, 12));
    chk("hand_c13", got_win[7], win9(3, 4, 0, 13, 14, 0, 23, 24, 0));
    chk("hand_c21", got_win[9], win9(11, 12, 13, 21, 22, 23, 0, 0, 0));
    chk("in_ready_low_cycles", WW'(low_cnt), WW'(H + W + 1));
    chk("frame_cycles", WW'(cyc_cnt), WW'(H * (W + 1) + W + 1));

    // Backpressure toggling every cycle plus random input gaps
    clear_q();
    rdy_mode = 1;
    send_frame(1'b1);
    in_valid = 1'b0;
    wait_windows("bp", W * H);
    compare_frame("bp", 0);
    rdy_mode = 0;
    @(posedge clk);
    #1;

    // Reset after six accepted pixels, then a full frame
    for (int i = 0; i < 6; i++) send_pixel(pix(i / W, i % W), 1'b0);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", WW'(out_valid), WW'(0));
    clear_q();
    @(posedge clk);
    #1;
    send_frame(1'b0);
    in_valid = 1'b0;
    wait_windows("midrst", W * H);
    compare_frame("midrst", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
